// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: register addresses,
// source bit positions and the padding returned in the unused IF bits.
package interrupt_controller_pkg;

  localparam logic [15:0] DEFAULT_ADDR_IF = 16'hFF0F;
  localparam logic [15:0] DEFAULT_ADDR_IE = 16'hFFFF;

  localparam int unsigned IRQ_COUNT  = 5;
  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  localparam logic [2:0] IF_READ_PAD = 3'b111;

endpackage

// File: rtl/interrupt_controller_irq_edge_capture.sv
// Rising-edge detector for one interrupt source. Runs on every clock so edges
// seen while the CPU clock enable is low are held until the next enabled cycle.
module irq_edge_capture (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Enable,
  input  logic i_Source,
  output logic o_Pending
);

  logic prev_level;
  logic sticky;
  logic rise;

  assign rise      = i_Source & ~prev_level;
  assign o_Pending = sticky | rise;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      prev_level <= 1'b0;
      sticky     <= 1'b0;
    end else begin
      prev_level <= i_Source;
      // An enabled cycle folds the pending edge into IF, so the sticky bit drops.
      if (i_Enable) sticky <= 1'b0;
      else          sticky <= sticky | rise;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped IF/IE interrupt controller: captures source edges, masks them
// with IE for the CPU, and clears the serviced flag on interrupt acknowledge.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [15:0] ADDR_IF = DEFAULT_ADDR_IF,
  parameter logic [15:0] ADDR_IE = DEFAULT_ADDR_IE
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Enable,
  input  logic [15:0]          i_Address,
  input  logic                 i_Address_Out,
  input  logic                 i_Bus_Out,
  input  logic                 i_Bus_In,
  input  logic [7:0]           i_Bus,
  input  logic [IRQ_COUNT-1:0] i_Sources,
  input  logic                 i_Handle_Interrupt,
  output logic [7:0]           o_Bus,
  output logic                 o_Selected,
  output logic [IRQ_COUNT-1:0] o_Interrupts
);

  logic [IRQ_COUNT-1:0] if_reg;
  logic [IRQ_COUNT-1:0] if_next;
  logic [IRQ_COUNT-1:0] pending;
  logic [IRQ_COUNT-1:0] ack_mask;
  logic [7:0]           ie_reg;
  logic                 ack_prev;
  logic                 sel_if;
  logic                 sel_ie;
  logic                 write_if;
  logic                 write_ie;
  logic                 found;

  for (genvar g = 0; g < IRQ_COUNT; g++) begin : g_capture
    irq_edge_capture u_capture (
      .i_Clk     (i_Clk),
      .i_Rst     (i_Rst),
      .i_Enable  (i_Enable),
      .i_Source  (i_Sources[g]),
      .o_Pending (pending[g])
    );
  end

  assign sel_if       = i_Address_Out && (i_Address == ADDR_IF);
  assign sel_ie       = i_Address_Out && (i_Address == ADDR_IE);
  assign o_Selected   = sel_if | sel_ie;
  assign write_if     = i_Enable & sel_if & i_Bus_Out;
  assign write_ie     = i_Enable & sel_ie & i_Bus_Out;
  assign o_Interrupts = if_reg & ie_reg[IRQ_COUNT-1:0];

  // Acknowledge only on the first cycle of a handle request; bit 0 wins.
  always_comb begin
    ack_mask = '0;
    found    = 1'b0;
    if (i_Handle_Interrupt && !ack_prev) begin
      for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
        if (!found && o_Interrupts[i]) begin
          ack_mask[i] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  assign if_next = ((write_if ? i_Bus[IRQ_COUNT-1:0] : if_reg) & ~ack_mask) | pending;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      if_reg   <= '0;
      ie_reg   <= '0;
      ack_prev <= 1'b0;
    end else if (i_Enable) begin
      if_reg   <= if_next;
      ack_prev <= i_Handle_Interrupt;
      if (write_ie) ie_reg <= i_Bus;
    end
  end

  always_comb begin
    o_Bus = '0;
    if (i_Bus_In) begin
      if (sel_if)      o_Bus = {IF_READ_PAD, if_reg};
      else if (sel_ie) o_Bus = ie_reg;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expectations are queued as
// stimulus is applied and compared once the outputs have settled.
module tb_interrupt_controller;

  localparam logic [15:0] A_IF = 16'hFF0F;
  localparam logic [15:0] A_IE = 16'hFFFF;

  localparam int K_BUS = 0;
  localparam int K_IRQ = 1;
  localparam int K_SEL = 2;

  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] address;
  logic        address_out;
  logic        bus_out;
  logic        bus_in;
  logic [7:0]  bus_wr;
  logic [4:0]  sources;
  logic        handle;
  logic [7:0]  bus_rd;
  logic        selected;
  logic [4:0]  interrupts;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_mismatch = 0;

  interrupt_controller #(.ADDR_IF(A_IF), .ADDR_IE(A_IE)) dut (
    .i_Clk              (clk),
    .i_Rst              (rst),
    .i_Enable           (enable),
    .i_Address          (address),
    .i_Address_Out      (address_out),
    .i_Bus_Out          (bus_out),
    .i_Bus_In           (bus_in),
    .i_Bus              (bus_wr),
    .i_Sources          (sources),
    .i_Handle_Interrupt (handle),
    .o_Bus              (bus_rd),
    .o_Selected         (selected),
    .o_Interrupts       (interrupts)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatch++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, observed, expected);
    end
  endtask

  task automatic expect_out(input int kind, input string tag, input logic [7:0] value);
    exp_t e;
    e.tag = tag; e.kind = kind; e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_BUS:   obs = bus_rd;
        K_IRQ:   obs = {3'b000, interrupts};
        default: obs = {7'b0, selected};
      endcase
      check_value(e.tag, obs, e.value);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_irq(input string tag, input logic [4:0] value);
    expect_out(K_IRQ, tag, {3'b000, value});
    drain();
  endtask

  task automatic read_reg(input string tag, input logic [15:0] addr, input logic [7:0] value);
    address = addr; address_out = 1'b1; bus_in = 1'b1;
    expect_out(K_BUS, tag, value);
    drain();
    address_out = 1'b0; bus_in = 1'b0;
  endtask

  task automatic write_reg(input logic [15:0] addr, input logic [7:0] data);
    address = addr; address_out = 1'b1; bus_out = 1'b1; bus_wr = data;
    tick();
    address_out = 1'b0; bus_out = 1'b0; bus_wr = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; address = 16'h0000; address_out = 1'b0;
    bus_out = 1'b0; bus_in = 1'b0; bus_wr = 8'h00; sources = 5'h00; handle = 1'b0;
    repeat (2) tick();

    // Reset state
    expect_out(K_IRQ, "rst_irq", 8'h00);
    expect_out(K_BUS, "rst_bus_idle", 8'h00);
    expect_out(K_SEL, "rst_sel_idle", 8'h00);
    drain();
    read_reg("rst_read_if", A_IF, 8'hE0);
    rst = 1'b0;
    tick();

    // Mid-operation reset with every flag set
    write_reg(A_IE, 8'hFF);
    write_reg(A_IF, 8'h1F);
    expect_irq("pre_rst_irq", 5'h1F);
    read_reg("pre_rst_if", A_IF, 8'hFF);
    #2 rst = 1'b1;
    expect_irq("midrst_irq", 5'h00);
    read_reg("midrst_if", A_IF, 8'hE0);
    read_reg("midrst_ie", A_IE, 8'h00);
    tick();
    rst = 1'b0;

    // An edge held while disabled is discarded by reset
    enable = 1'b0;
    sources[1] = 1'b1; tick();
    sources[1] = 1'b0; tick();
    #2 rst = 1'b1; #1 rst = 1'b0;
    enable = 1'b1;
    write_reg(A_IE, 8'hFF);
    tick();
    expect_irq("rst_drops_sticky", 5'h00);

    // Edge capture with partial enable mask
    write_reg(A_IE, 8'h05);
    sources = 5'b00101; tick();
    sources = 5'h00; tick();
    read_reg("edge_if", A_IF, 8'hE5);
    expect_irq("edge_irq", 5'h05);

    // Held acknowledge clears only the highest-priority flag once
    handle = 1'b1;
    tick();
    expect_irq("ack_first", 5'h04);
    tick(); tick();
    handle = 1'b0;
    tick();
    expect_irq("ack_held", 5'h04);
    read_reg("ack_if", A_IF, 8'hE4);

    // New edge beats a same-cycle IF write
    write_reg(A_IE, 8'h08);
    address = A_IF; address_out = 1'b1; bus_out = 1'b1; bus_wr = 8'h00;
    sources[3] = 1'b1;
    tick();
    address_out = 1'b0; bus_out = 1'b0;
    read_reg("set_beats_write_if", A_IF, 8'hE8);
    expect_irq("set_beats_write_irq", 5'h08);
    sources[3] = 1'b0;
    tick();

    // Edge during a stalled clock enable lands on the next enabled edge
    write_reg(A_IE, 8'h18);
    enable = 1'b0;
    sources[4] = 1'b1; tick();
    sources[4] = 1'b0; tick(); tick(); tick();
    expect_irq("stall_irq", 5'h08);
    enable = 1'b1;
    tick();
    read_reg("stall_if", A_IF, 8'hF8);
    expect_irq("stall_release_irq", 5'h18);

    // Address decode
    address = 16'hFF10; address_out = 1'b1; bus_in = 1'b1;
    expect_out(K_BUS, "unsel_bus", 8'h00);
    expect_out(K_SEL, "unsel_sel", 8'h00);
    drain();
    address = A_IE;
    expect_out(K_SEL, "sel_ie", 8'h01);
    expect_out(K_BUS, "sel_ie_bus", 8'h18);
    drain();
    address_out = 1'b0; bus_in = 1'b0;

    // Source held high across an acknowledge does not re-raise
    write_reg(A_IF, 8'h00);
    sources[3] = 1'b1; tick();
    expect_irq("held_set", 5'h08);
    handle = 1'b1; tick();
    handle = 1'b0;
    expect_irq("held_ack", 5'h00);
    tick(); tick();
    expect_irq("held_stays_clear", 5'h00);
    sources[3] = 1'b0; tick();
    sources[3] = 1'b1; tick();
    expect_irq("held_new_edge", 5'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
